sram_banked_dp: RTL and testbench

// Dual-port, multi-bank SRAM with byte-enable writes and a fixed, parametrised read latency.

---
 rtl/sram_pkg.sv | 21 ++
 rtl/sram_bank.sv | 28 ++
 rtl/sram_banked_dp.sv | 167 ++++++++++++++++
 tb/tb_sram_banked_dp.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the banked dual-port SRAM.
package sram_pkg;

  localparam int MAX_DATA_W = 128;
  localparam int MAX_ADDR_W = 32;

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  // Sized for the widest configuration; the top only fills the low bits.
  typedef struct packed {
    logic                    we;
    logic [MAX_ADDR_W-1:0]   addr;
    logic [MAX_DATA_W-1:0]   wdata;
    logic [MAX_DATA_W/8-1:0] be;
  } sram_req_t;

  function automatic int bank_w(input int nb);
    return $clog2(nb);
  endfunction

endpackage

// File: rtl/sram_bank.sv
// Single-port bank: byte-enable write, registered one-cycle read.
module sram_bank #(
  parameter int DATA_W = 32,
  parameter int ROW_W  = 8
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [ROW_W-1:0]    row,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem_q [2**ROW_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < DATA_W/8; i++)
        if (be[i]) mem_q[row][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    if (en && !we) rdata_q <= mem_q[row];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_banked_dp.sv
// Dual-port word-interleaved banked SRAM with round-robin conflict arbitration
// and a fixed read latency of READ_LAT cycles.
module sram_banked_dp
  import sram_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int NUM_BANKS = 4,
  parameter int READ_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  input  logic [DATA_W/8-1:0] a_be,
  output logic                a_gnt,
  output logic                a_rvalid,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  input  logic [DATA_W/8-1:0] b_be,
  output logic                b_gnt,
  output logic                b_rvalid,
  output logic [DATA_W-1:0]   b_rdata
);

  localparam int BANK_W = bank_w(NUM_BANKS);
  localparam int ROW_W  = ADDR_W - BANK_W;
  localparam int BE_W   = DATA_W / 8;

  sram_req_t               preq [2];
  logic [1:0]              req, gnt, rd_acc;
  logic [1:0][BANK_W-1:0]  bsel;
  logic                    conflict;
  port_e                   rr_pri_d, rr_pri_q;
  logic                    unused_hi;

  always_comb begin
    preq[0] = '0;
    preq[0].we                  = a_we;
    preq[0].addr[ADDR_W-1:0]    = a_addr;
    preq[0].wdata[DATA_W-1:0]   = a_wdata;
    preq[0].be[BE_W-1:0]        = a_be;
    preq[1] = '0;
    preq[1].we                  = b_we;
    preq[1].addr[ADDR_W-1:0]    = b_addr;
    preq[1].wdata[DATA_W-1:0]   = b_wdata;
    preq[1].be[BE_W-1:0]        = b_be;
  end

  // Struct bits above the configured widths are constant zero.
  assign unused_hi = ^{preq[0], preq[1]};

  assign req     = {b_req, a_req};
  assign bsel[0] = preq[0].addr[BANK_W-1:0];
  assign bsel[1] = preq[1].addr[BANK_W-1:0];

  always_comb begin
    conflict = req[0] && req[1] && (bsel[0] == bsel[1]);
    gnt[0]   = !rst && req[0] && (!conflict || rr_pri_q == PORT_A);
    gnt[1]   = !rst && req[1] && (!conflict || rr_pri_q == PORT_B);
    rd_acc[0] = gnt[0] && !preq[0].we;
    rd_acc[1] = gnt[1] && !preq[1].we;
    rr_pri_d = rr_pri_q;
    if (conflict) rr_pri_d = (rr_pri_q == PORT_A) ? PORT_B : PORT_A;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_pri_q <= PORT_A;
    else     rr_pri_q <= rr_pri_d;
  end

  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];

  logic [NUM_BANKS-1:0]             bk_en, bk_we;
  logic [NUM_BANKS-1:0][ROW_W-1:0]  bk_row;
  logic [NUM_BANKS-1:0][DATA_W-1:0] bk_wdata, bk_rdata;
  logic [NUM_BANKS-1:0][BE_W-1:0]   bk_be;

  // Arbitration guarantees at most one granted port per bank.
  always_comb begin
    for (int k = 0; k < NUM_BANKS; k++) begin
      logic sa, sb;
      sa = gnt[0] && (bsel[0] == BANK_W'(k));
      sb = gnt[1] && (bsel[1] == BANK_W'(k));
      bk_en[k]    = sa || sb;
      bk_we[k]    = sa ? preq[0].we                       : preq[1].we;
      bk_row[k]   = sa ? preq[0].addr[ADDR_W-1:BANK_W]    : preq[1].addr[ADDR_W-1:BANK_W];
      bk_wdata[k] = sa ? preq[0].wdata[DATA_W-1:0]        : preq[1].wdata[DATA_W-1:0];
      bk_be[k]    = sa ? preq[0].be[BE_W-1:0]             : preq[1].be[BE_W-1:0];
    end
  end

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    sram_bank #(.DATA_W(DATA_W), .ROW_W(ROW_W)) u_bank (
      .clk   (clk),
      .en    (bk_en[k]),
      .we    (bk_we[k]),
      .row   (bk_row[k]),
      .wdata (bk_wdata[k]),
      .be    (bk_be[k]),
      .rdata (bk_rdata[k])
    );
  end

  // Tag remembers which bank returns data for each port one cycle after accept.
  logic [1:0][BANK_W-1:0]   tag_d, tag_q;
  logic [1:0][READ_LAT-1:0] vld_d, vld_q;
  logic [1:0][DATA_W-1:0]   stage0, fin_dat, rdata_d, rdata_q;
  logic [1:0]               fin_vld;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      tag_d[p]    = rd_acc[p] ? bsel[p] : tag_q[p];
      vld_d[p][0] = rd_acc[p];
      for (int i = 1; i < READ_LAT; i++) vld_d[p][i] = vld_q[p][i-1];
      stage0[p]   = bk_rdata[tag_q[p]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  if (READ_LAT > 1) begin : g_xtra
    logic [1:0][READ_LAT-2:0][DATA_W-1:0] dat_d, dat_q;
    always_comb begin
      for (int p = 0; p < 2; p++) begin
        dat_d[p][0] = stage0[p];
        for (int i = 1; i < READ_LAT-1; i++) dat_d[p][i] = dat_q[p][i-1];
        fin_dat[p]  = dat_q[p][READ_LAT-2];
      end
    end
    always_ff @(posedge clk) dat_q <= dat_d;
  end else begin : g_noxtra
    assign fin_dat = stage0;
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fin_vld[p] = vld_q[p][READ_LAT-1];
      rdata_d[p] = fin_vld[p] ? fin_dat[p] : rdata_q[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign a_rvalid = fin_vld[0];
  assign b_rvalid = fin_vld[1];
  assign a_rdata  = rdata_d[0];
  assign b_rdata  = rdata_d[1];

endmodule

// File: tb/tb_sram_banked_dp.sv
// Directed bench for sram_banked_dp with READ_LAT=3.
module tb_sram_banked_dp;
  localparam int DW = 32, AW = 10, NB = 4, RL = 3;

  logic          clk = 1'b0, rst;
  logic          a_req, a_we, a_gnt, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic [3:0]    a_be;
  logic          b_req, b_we, b_gnt, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic [3:0]    b_be;

  int tests = 0, fails = 0;

  sram_banked_dp #(.DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick; @(posedge clk); #1; endtask

  task automatic idle; a_req = 1'b0; b_req = 1'b0; endtask

  task automatic drive(input bit pb, input bit we, input logic [AW-1:0] ad,
                       input logic [DW-1:0] wd, input logic [3:0] be);
    if (!pb) begin a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = wd; a_be = be; end
    else     begin b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = wd; b_be = be; end
  endtask

  // Entered one cycle after the accepting edge; returns cycles to rvalid (10 = timeout).
  task automatic wait_rd(input bit pb, output int lat, output logic [DW-1:0] d);
    lat = 1;
    while (!(pb ? b_rvalid : a_rvalid) && lat < 10) begin tick; lat++; end
    d = pb ? b_rdata : a_rdata;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(0, 0, 10'h002, '0, '0);
    drive(1, 0, 10'h006, '0, '0);
    for (int c = 0; c < 2; c++) begin
      tick;
      tests++;
      if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== 4'b0) begin
        fails++; $display("FAIL reset_ctl[%0d]: got %b exp 0000", c, {a_gnt, b_gnt, a_rvalid, b_rvalid});
      end
      tests++;
      if ({a_rdata, b_rdata} !== 64'h0) begin
        fails++; $display("FAIL reset_rdata[%0d]: got %h exp 0", c, {a_rdata, b_rdata});
      end
    end
    rst = 1'b0; idle; tick;
  endtask

  task automatic test_byte_en;
    int lat; logic [DW-1:0] d;
    drive(0, 1, 10'h005, 32'h11223344, 4'hF); #1;
    tests++; if (a_gnt !== 1'b1) begin fails++; $display("FAIL be_wr1_gnt: got %b exp 1", a_gnt); end
    tick;
    drive(0, 1, 10'h005, 32'hAABBCCDD, 4'b0101); #1;
    tests++; if (a_gnt !== 1'b1) begin fails++; $display("FAIL be_wr2_gnt: got %b exp 1", a_gnt); end
    tick;
    drive(0, 0, 10'h005, '0, '0); #1;
    tests++; if (a_gnt !== 1'b1) begin fails++; $display("FAIL be_rd_gnt: got %b exp 1", a_gnt); end
    tick; idle;
    wait_rd(0, lat, d);
    tests++; if (lat != RL) begin fails++; $display("FAIL be_lat: got %0d exp %0d", lat, RL); end
    tests++; if (d !== 32'h11BB33DD) begin fails++; $display("FAIL be_data: got %h exp 11bb33dd", d); end
    tick;
    tests++; if (a_rvalid !== 1'b0) begin fails++; $display("FAIL be_pulse: got %b exp 0", a_rvalid); end
    tests++; if (a_rdata !== 32'h11BB33DD) begin fails++; $display("FAIL be_hold: got %h exp 11bb33dd", a_rdata); end
  endtask

  task automatic test_parallel;
    int lat; logic [DW-1:0] d;
    drive(0, 1, 10'h004, 32'h0BADCAFE, 4'hF); tick; idle;
    drive(0, 0, 10'h004, '0, '0);
    drive(1, 1, 10'h001, 32'hCAFEF00D, 4'hF); #1;
    tests++; if ({b_gnt, a_gnt} !== 2'b11) begin fails++; $display("FAIL par_gnt: got %b exp 11", {b_gnt, a_gnt}); end
    tick; idle;
    wait_rd(0, lat, d);
    tests++; if (lat != RL) begin fails++; $display("FAIL par_lat: got %0d exp %0d", lat, RL); end
    tests++; if (d !== 32'h0BADCAFE) begin fails++; $display("FAIL par_data: got %h exp 0badcafe", d); end
    tests++; if (b_rvalid !== 1'b0) begin fails++; $display("FAIL par_wr_norv: got %b exp 0", b_rvalid); end
    tick;
    drive(1, 0, 10'h001, '0, '0); tick; idle;
    wait_rd(1, lat, d);
    tests++; if (d !== 32'hCAFEF00D) begin fails++; $display("FAIL par_bdata: got %h exp cafef00d", d); end
  endtask

  task automatic test_conflict;
    int lat; logic [DW-1:0] d; logic [1:0] exp_g;
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, 10'h002, 32'h22222222, 4'hF);
      drive(1, 1, 10'h006, 32'h66666666, 4'hF); #1;
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
      tests++;
      if ({b_gnt, a_gnt} !== exp_g) begin
        fails++; $display("FAIL conflict_gnt[%0d]: got %b exp %b", c, {b_gnt, a_gnt}, exp_g);
      end
      tick;
    end
    idle;
    drive(0, 0, 10'h002, '0, '0); tick; idle;
    wait_rd(0, lat, d);
    tests++; if (d !== 32'h22222222) begin fails++; $display("FAIL conflict_adata: got %h exp 22222222", d); end
    drive(1, 0, 10'h006, '0, '0); tick; idle;
    wait_rd(1, lat, d);
    tests++; if (d !== 32'h66666666) begin fails++; $display("FAIL conflict_bdata: got %h exp 66666666", d); end
  endtask

  task automatic test_raw;
    int lat; logic [DW-1:0] d;
    drive(1, 1, 10'h3FF, 32'hDEADBEEF, 4'hF); #1;
    tests++; if (b_gnt !== 1'b1) begin fails++; $display("FAIL raw_wgnt: got %b exp 1", b_gnt); end
    tick; idle;
    drive(0, 0, 10'h3FF, '0, '0); #1;
    tests++; if (a_gnt !== 1'b1) begin fails++; $display("FAIL raw_rgnt: got %b exp 1", a_gnt); end
    tick; idle;
    wait_rd(0, lat, d);
    tests++; if (lat != RL) begin fails++; $display("FAIL raw_lat: got %0d exp %0d", lat, RL); end
    tests++; if (d !== 32'hDEADBEEF) begin fails++; $display("FAIL raw_data: got %h exp deadbeef", d); end
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] ad [3];
    logic [DW-1:0] ex [3];
    ad = '{10'h005, 10'h002, 10'h004};
    ex = '{32'h11BB33DD, 32'h22222222, 32'h0BADCAFE};
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, ad[i], '0, '0); #1;
      tests++; if (a_gnt !== 1'b1) begin fails++; $display("FAIL b2b_gnt[%0d]: got %b exp 1", i, a_gnt); end
      tick;
    end
    idle;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (a_rvalid !== 1'b1 || a_rdata !== ex[i]) begin
        fails++; $display("FAIL b2b_rd[%0d]: got v=%b %h exp v=1 %h", i, a_rvalid, a_rdata, ex[i]);
      end
      tick;
    end
    tests++; if (a_rvalid !== 1'b0) begin fails++; $display("FAIL b2b_end: got %b exp 0", a_rvalid); end
  endtask

  task automatic test_reset_mid;
    int lat, seen; logic [DW-1:0] d;
    drive(0, 0, 10'h005, '0, '0);
    drive(1, 0, 10'h001, '0, '0); #1;
    tests++; if ({b_gnt, a_gnt} !== 2'b01) begin fails++; $display("FAIL rmid_gnt: got %b exp 01", {b_gnt, a_gnt}); end
    tick; idle;
    rst = 1'b1; tick; rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (a_rvalid || b_rvalid) seen++;
      tick;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL rmid_flush: got %0d rvalid cycles exp 0", seen); end
    tests++; if (a_rdata !== 32'h0) begin fails++; $display("FAIL rmid_rdata: got %h exp 0", a_rdata); end
    drive(0, 0, 10'h005, '0, '0);
    drive(1, 0, 10'h001, '0, '0); #1;
    tests++; if ({b_gnt, a_gnt} !== 2'b01) begin fails++; $display("FAIL rmid_pri: got %b exp 01", {b_gnt, a_gnt}); end
    tick; idle;
    wait_rd(0, lat, d);
    tests++; if (d !== 32'h11BB33DD) begin fails++; $display("FAIL rmid_data: got %h exp 11bb33dd", d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; idle;
    a_we = 0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_we = 0; b_addr = '0; b_wdata = '0; b_be = '0;
    #1;
    test_reset;
    test_byte_en;
    test_parallel;
    test_conflict;
    test_raw;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
